// File: rtl/lcd_sequencer_if.sv
// ============================================================================
// Module      : lcd_sequencer_if
// Description : Sequencer <-> LCD controller transfer bus (data, RS, start,
//               done).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lcd_sequencer_if;
    logic [7:0] oLCD_DATA;
    logic       oLCD_RS;
    logic       oLCD_START;
    logic       iLCD_DONE;

    modport master (
        output oLCD_DATA,
        output oLCD_RS,
        output oLCD_START,
        input  iLCD_DONE
    );

    modport slave (
        input  oLCD_DATA,
        input  oLCD_RS,
        input  oLCD_START,
        output iLCD_DONE
    );
endinterface

`default_nettype wire

// File: rtl/lcd_sequencer.sv
// ============================================================================
// Module      : lcd_sequencer
// Description : Sends the LCD init list once per reset, then redraws a 32-char
//               buffer as two lines on every refresh request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_sequencer #(
    parameter int INIT_DELAY = 50000,
    parameter int CMD_DELAY  = 2000,
    parameter int CLR_DELAY  = 100000
) (
    input  wire logic       iCLK,
    input  wire logic       iRST_N,
    input  wire logic       iWR,
    input  wire logic [4:0] iWADDR,
    input  wire logic [7:0] iWDATA,
    input  wire logic       iREFRESH,
    output logic            oBUSY,
    lcd_sequencer_if.master lcd
);

    localparam int MAX_A     = (INIT_DELAY > CMD_DELAY) ? INIT_DELAY : CMD_DELAY;
    localparam int MAX_DELAY = (MAX_A > CLR_DELAY) ? MAX_A : CLR_DELAY;
    localparam int CNT_W     = (MAX_DELAY < 1) ? 1 : $clog2(MAX_DELAY + 1);

    typedef enum logic [2:0] {
        PWR_WAIT  = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4,
        IDLE      = 3'd5
    } state_t;

    state_t           state;
    state_t           nextState;
    logic [CNT_W-1:0] delayCnt;
    logic [5:0]       idx;
    logic             inInit;
    logic             pending;
    logic             doneQ;
    logic [7:0]       dataReg;
    logic             rsReg;
    logic             startReg;
    logic [7:0]       charBuf [32];

    logic             doneRise;
    logic [31:0]      curLimit;
    logic             delayEnd;
    logic             lastEntry;
    logic [7:0]       loadData;
    logic             loadRs;
    logic [4:0]       lineOneAddr;
    logic [4:0]       lineTwoAddr;

    // Only a fresh 0->1 edge completes a transfer; a level left high from the
    // previous transfer is ignored.
    assign doneRise    = lcd.iLCD_DONE & ~doneQ;
    assign lastEntry   = inInit ? (idx == 6'd3) : (idx == 6'd33);
    assign lineOneAddr = 5'(idx - 6'd1);
    assign lineTwoAddr = 5'(idx - 6'd2);

    always_comb begin
        curLimit = 32'(CMD_DELAY);
        if (state == PWR_WAIT) begin
            curLimit = 32'(INIT_DELAY);
        end else if (inInit && (idx == 6'd2)) begin
            curLimit = 32'(CLR_DELAY);
        end
    end

    assign delayEnd = ((32'(delayCnt) + 32'd1) >= curLimit);

    // Transfer index -> byte: init list, or 0x80, line 1, 0xC0, line 2.
    always_comb begin
        loadData = 8'h00;
        loadRs   = 1'b0;
        if (inInit) begin
            case (idx)
                6'd0:    loadData = 8'h38;
                6'd1:    loadData = 8'h0C;
                6'd2:    loadData = 8'h01;
                default: loadData = 8'h06;
            endcase
        end else if (idx == 6'd0) begin
            loadData = 8'h80;
        end else if (idx == 6'd17) begin
            loadData = 8'hC0;
        end else if (idx <= 6'd16) begin
            loadData = charBuf[lineOneAddr];
            loadRs   = 1'b1;
        end else begin
            loadData = charBuf[lineTwoAddr];
            loadRs   = 1'b1;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            PWR_WAIT:  if (delayEnd) nextState = LOAD;
            LOAD:      nextState = START;
            START:     nextState = WAIT_DONE;
            WAIT_DONE: if (doneRise) nextState = GAP;
            GAP: begin
                if (delayEnd) begin
                    nextState = (!inInit && lastEntry) ? IDLE : LOAD;
                end
            end
            IDLE:      if (pending) nextState = LOAD;
            default:   nextState = PWR_WAIT;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state    <= PWR_WAIT;
            delayCnt <= '0;
            idx      <= 6'd0;
            inInit   <= 1'b1;
            pending  <= 1'b0;
            doneQ    <= 1'b0;
            dataReg  <= 8'h00;
            rsReg    <= 1'b0;
            startReg <= 1'b0;
        end else begin
            state    <= nextState;
            doneQ    <= lcd.iLCD_DONE;
            // A request in the cycle IDLE consumes the flag still re-arms it.
            pending  <= (pending & (state != IDLE)) | iREFRESH;
            startReg <= (nextState == START) || (nextState == WAIT_DONE);

            if (state == LOAD) begin
                dataReg <= loadData;
                rsReg   <= loadRs;
            end

            if (nextState != state) begin
                delayCnt <= '0;
            end else if ((state == PWR_WAIT) || (state == GAP)) begin
                delayCnt <= delayCnt + 1'b1;
            end

            if ((state == GAP) && delayEnd) begin
                if (inInit && lastEntry) begin
                    idx    <= 6'd0;
                    inInit <= 1'b0;
                end else if (!lastEntry) begin
                    idx <= idx + 6'd1;
                end
            end else if ((state == IDLE) && pending) begin
                idx <= 6'd0;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < 32; i++) begin
                charBuf[i] <= 8'h20;
            end
        end else if (iWR) begin
            charBuf[iWADDR] <= iWDATA;
        end
    end

    // Data is shown live during LOAD, then frozen for the rest of the transfer.
    assign lcd.oLCD_DATA  = (state == LOAD) ? loadData : dataReg;
    assign lcd.oLCD_RS    = (state == LOAD) ? loadRs : rsReg;
    assign lcd.oLCD_START = startReg;
    assign oBUSY          = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_lcd_sequencer.sv
// ============================================================================
// Module      : tb_lcd_sequencer
// Description : Self-checking bench for lcd_sequencer with an LCD controller
//               model and a transfer-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_sequencer;

    logic       iCLK     = 1'b0;
    logic       iRST_N   = 1'b0;
    logic       iWR      = 1'b0;
    logic [4:0] iWADDR   = 5'd0;
    logic [7:0] iWDATA   = 8'd0;
    logic       iREFRESH = 1'b0;
    logic       oBUSY;

    lcd_sequencer_if lcdIf ();

    lcd_sequencer #(
        .INIT_DELAY(10),
        .CMD_DELAY (4),
        .CLR_DELAY (8)
    ) dut (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .iWR     (iWR),
        .iWADDR  (iWADDR),
        .iWDATA  (iWDATA),
        .iREFRESH(iREFRESH),
        .oBUSY   (oBUSY),
        .lcd     (lcdIf)
    );

    always #5 iCLK = ~iCLK;

    int tests = 0;
    int fails = 0;
    int stuckHold = 0;
    int cycle = 0;
    int stabErr = 0;
    int lowCnt = 0;
    int highCnt = 0;

    logic [7:0] capData [$];
    logic       capRs   [$];
    int         capLow  [$];
    int         capHigh [$];
    int         capCyc  [$];
    logic [7:0] expData [$];
    logic       expRs   [$];
    logic [7:0] modelBuf [32];

    // Transfer monitor: one record per rising edge of start.
    initial begin
        logic       prev;
        logic [7:0] held;
        logic       heldRs;
        prev = 1'b0;
        held = 8'h00;
        heldRs = 1'b0;
        forever begin
            @(negedge iCLK);
            cycle++;
            if (lcdIf.oLCD_START === 1'b1) begin
                if (!prev) begin
                    capData.push_back(lcdIf.oLCD_DATA);
                    capRs.push_back(lcdIf.oLCD_RS);
                    capLow.push_back(lowCnt);
                    capCyc.push_back(cycle);
                    held = lcdIf.oLCD_DATA;
                    heldRs = lcdIf.oLCD_RS;
                    highCnt = 0;
                end else if ((lcdIf.oLCD_DATA !== held) || (lcdIf.oLCD_RS !== heldRs)) begin
                    stabErr++;
                end
                highCnt++;
                prev = 1'b1;
            end else begin
                if (prev) begin
                    capHigh.push_back(highCnt);
                    lowCnt = 1;
                end else begin
                    lowCnt++;
                end
                prev = 1'b0;
            end
        end
    end

    // LCD controller model: done drops after the request, rises a few cycles later.
    initial begin
        lcdIf.iLCD_DONE = 1'b0;
        forever begin
            @(posedge lcdIf.oLCD_START);
            repeat (1 + stuckHold) @(posedge iCLK);
            #1 lcdIf.iLCD_DONE = 1'b0;
            repeat ($urandom_range(2, 5)) @(posedge iCLK);
            #1 lcdIf.iLCD_DONE = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic clearCap();
        capData.delete();
        capRs.delete();
        capLow.delete();
        capHigh.delete();
        capCyc.delete();
        expData.delete();
        expRs.delete();
        stabErr = 0;
    endtask

    function automatic void addInit();
        logic [7:0] initList [4];
        initList = '{8'h38, 8'h0C, 8'h01, 8'h06};
        for (int i = 0; i < 4; i++) begin
            expData.push_back(initList[i]);
            expRs.push_back(1'b0);
        end
    endfunction

    function automatic void addPass();
        expData.push_back(8'h80);
        expRs.push_back(1'b0);
        for (int i = 0; i < 16; i++) begin
            expData.push_back(modelBuf[i]);
            expRs.push_back(1'b1);
        end
        expData.push_back(8'hC0);
        expRs.push_back(1'b0);
        for (int i = 16; i < 32; i++) begin
            expData.push_back(modelBuf[i]);
            expRs.push_back(1'b1);
        end
    endfunction

    // Idle means oBUSY low for three consecutive samples (IDLE between passes is one cycle).
    task automatic waitIdle(input int budget, output bit ok);
        int run;
        run = 0;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            run = (oBUSY === 1'b0) ? run + 1 : 0;
            if (run >= 3) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic waitTransfers(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (capData.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulseRefresh();
        iREFRESH = 1'b1;
        tick(1);
        iREFRESH = 1'b0;
    endtask

    task automatic writeBuf(input logic [4:0] a, input logic [7:0] d);
        iWR = 1'b1;
        iWADDR = a;
        iWDATA = d;
        tick(1);
        iWR = 1'b0;
        modelBuf[a] = d;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32; i++) modelBuf[i] = 8'h20;
        iRST_N = 1'b0;
        tick(3);
        tests++;
        if (lcdIf.oLCD_START !== 1'b0) begin
            fails++;
            $display("FAIL reset_start: got %b, required 0", lcdIf.oLCD_START);
        end
        tests++;
        if (lcdIf.oLCD_DATA !== 8'h00) begin
            fails++;
            $display("FAIL reset_data: got %h, required 00", lcdIf.oLCD_DATA);
        end
        tests++;
        if (lcdIf.oLCD_RS !== 1'b0) begin
            fails++;
            $display("FAIL reset_rs: got %b, required 0", lcdIf.oLCD_RS);
        end
        tests++;
        if (oBUSY !== 1'b1) begin
            fails++;
            $display("FAIL reset_busy: got %b, required 1", oBUSY);
        end
    endtask

    task automatic test_init_pass();
        bit ok;
        int rel;
        int need;
        clearCap();
        addInit();
        addPass();
        iRST_N = 1'b1;
        rel = cycle;
        waitIdle(3000, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL init_idle: oBUSY=%b after budget, required 0", oBUSY);
        end
        tests++;
        if (capData.size() != expData.size()) begin
            fails++;
            $display("FAIL init_count: got %0d transfers, required %0d", capData.size(), expData.size());
        end
        for (int i = 0; i < expData.size() && i < capData.size(); i++) begin
            tests++;
            if ((capData[i] !== expData[i]) || (capRs[i] !== expRs[i])) begin
                fails++;
                $display("FAIL init_byte[%0d]: got %h/rs%b, required %h/rs%b",
                         i, capData[i], capRs[i], expData[i], expRs[i]);
            end
        end
        if (capCyc.size() > 0) begin
            tests++;
            if (capCyc[0] - rel < 10) begin
                fails++;
                $display("FAIL init_delay: first start after %0d cycles, required >= 10", capCyc[0] - rel);
            end
        end
        for (int i = 1; i < expData.size() && i < capLow.size(); i++) begin
            need = (expRs[i-1] == 1'b0 && expData[i-1] == 8'h01) ? 8 : 4;
            tests++;
            if (capLow[i] < need) begin
                fails++;
                $display("FAIL init_gap[%0d]: start low %0d cycles, required >= %0d", i, capLow[i], need);
            end
        end
        tests++;
        if (stabErr != 0) begin
            fails++;
            $display("FAIL init_stable: %0d data changes while start high, required 0", stabErr);
        end
    endtask

    task automatic test_refresh_data();
        bit ok;
        for (int i = 0; i < 10; i++) begin
            writeBuf(5'($urandom_range(0, 31)), 8'($urandom_range(33, 126)));
        end
        writeBuf(5'd0, 8'h48);
        writeBuf(5'd31, 8'h21);
        clearCap();
        addPass();
        pulseRefresh();
        tick(2);
        waitIdle(3000, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL refresh_idle: oBUSY=%b after budget, required 0", oBUSY);
        end
        tests++;
        if (capData.size() != 34) begin
            fails++;
            $display("FAIL refresh_count: got %0d transfers, required 34", capData.size());
        end
        for (int i = 0; i < 34 && i < capData.size(); i++) begin
            tests++;
            if ((capData[i] !== expData[i]) || (capRs[i] !== expRs[i])) begin
                fails++;
                $display("FAIL refresh_byte[%0d]: got %h/rs%b, required %h/rs%b",
                         i, capData[i], capRs[i], expData[i], expRs[i]);
            end
        end
        if (capData.size() >= 34) begin
            tests++;
            if ((capData[1] !== 8'h48) || (capRs[1] !== 1'b1)) begin
                fails++;
                $display("FAIL refresh_first_char: got %h/rs%b, required 48/rs1", capData[1], capRs[1]);
            end
            tests++;
            if ((capData[33] !== 8'h21) || (capRs[33] !== 1'b1)) begin
                fails++;
                $display("FAIL refresh_last_char: got %h/rs%b, required 21/rs1", capData[33], capRs[33]);
            end
        end
        for (int i = 1; i < capLow.size(); i++) begin
            tests++;
            if (capLow[i] < 4) begin
                fails++;
                $display("FAIL refresh_gap[%0d]: start low %0d cycles, required >= 4", i, capLow[i]);
            end
        end
    endtask

    task automatic test_multi_refresh();
        bit ok;
        clearCap();
        addPass();
        addPass();
        pulseRefresh();
        waitTransfers(3, 200, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL multi_start: got %0d transfers, required >= 3", capData.size());
        end
        for (int k = 0; k < 3; k++) begin
            tick($urandom_range(5, 40));
            pulseRefresh();
        end
        waitIdle(4000, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL multi_idle: oBUSY=%b after budget, required 0", oBUSY);
        end
        tick(40);
        tests++;
        if (oBUSY !== 1'b0) begin
            fails++;
            $display("FAIL multi_stay_idle: oBUSY=%b, required 0", oBUSY);
        end
        tests++;
        if (capData.size() != 68) begin
            fails++;
            $display("FAIL multi_count: got %0d transfers, required 68", capData.size());
        end
        for (int i = 0; i < 68 && i < capData.size(); i++) begin
            tests++;
            if ((capData[i] !== expData[i]) || (capRs[i] !== expRs[i])) begin
                fails++;
                $display("FAIL multi_byte[%0d]: got %h/rs%b, required %h/rs%b",
                         i, capData[i], capRs[i], expData[i], expRs[i]);
            end
        end
    endtask

    task automatic test_stuck_done();
        bit ok;
        clearCap();
        addPass();
        stuckHold = 12;
        tests++;
        if (lcdIf.iLCD_DONE !== 1'b1) begin
            fails++;
            $display("FAIL stuck_precond: done=%b before pass, required 1", lcdIf.iLCD_DONE);
        end
        pulseRefresh();
        tick(2);
        waitIdle(4000, ok);
        stuckHold = 0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL stuck_idle: oBUSY=%b after budget, required 0", oBUSY);
        end
        tests++;
        if (capData.size() != 34) begin
            fails++;
            $display("FAIL stuck_count: got %0d transfers, required 34", capData.size());
        end
        for (int i = 0; i < capHigh.size(); i++) begin
            tests++;
            if (capHigh[i] < 14) begin
                fails++;
                $display("FAIL stuck_hold[%0d]: start high %0d cycles, required >= 14", i, capHigh[i]);
            end
        end
        for (int i = 0; i < 34 && i < capData.size(); i++) begin
            tests++;
            if ((capData[i] !== expData[i]) || (capRs[i] !== expRs[i])) begin
                fails++;
                $display("FAIL stuck_byte[%0d]: got %h/rs%b, required %h/rs%b",
                         i, capData[i], capRs[i], expData[i], expRs[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int rel;
        clearCap();
        pulseRefresh();
        waitTransfers(6, 300, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL midrst_progress: got %0d transfers, required >= 6", capData.size());
        end
        for (int i = 0; i < 40 && lcdIf.oLCD_START !== 1'b1; i++) tick(1);
        iRST_N = 1'b0;
        #1;
        tests++;
        if (lcdIf.oLCD_START !== 1'b0) begin
            fails++;
            $display("FAIL midrst_start: got %b, required 0", lcdIf.oLCD_START);
        end
        tests++;
        if (oBUSY !== 1'b1) begin
            fails++;
            $display("FAIL midrst_busy: got %b, required 1", oBUSY);
        end
        for (int i = 0; i < 32; i++) modelBuf[i] = 8'h20;
        tick(3);
        clearCap();
        addInit();
        addPass();
        iRST_N = 1'b1;
        rel = cycle;
        waitIdle(3000, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL midrst_idle: oBUSY=%b after budget, required 0", oBUSY);
        end
        tests++;
        if (capData.size() != 38) begin
            fails++;
            $display("FAIL midrst_count: got %0d transfers, required 38", capData.size());
        end
        if (capCyc.size() > 0) begin
            tests++;
            if (capCyc[0] - rel < 10) begin
                fails++;
                $display("FAIL midrst_delay: first start after %0d cycles, required >= 10", capCyc[0] - rel);
            end
        end
        for (int i = 0; i < 38 && i < capData.size(); i++) begin
            tests++;
            if ((capData[i] !== expData[i]) || (capRs[i] !== expRs[i])) begin
                fails++;
                $display("FAIL midrst_byte[%0d]: got %h/rs%b, required %h/rs%b",
                         i, capData[i], capRs[i], expData[i], expRs[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_init_pass();
        test_refresh_data();
        test_multi_refresh();
        test_stuck_done();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
